// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding and default width for the ALU
package alu_pkg;
    localparam int ALU_WIDTH = 8;
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_XOR = 3'b011
    } alu_op_t;
endpackage

// File: rtl/alu_unit_if.sv
// alu_unit_if: operand/opcode request and registered result bundle
interface alu_unit_if #(parameter int WIDTH = alu_pkg::ALU_WIDTH);
    logic             in_valid;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       op;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             out_valid;
    modport master (output in_valid, in1, in2, op, input out, zero, out_valid);
    modport slave  (input in_valid, in1, in2, op, output out, zero, out_valid);
endinterface

// File: rtl/alu_unit_datapath.sv
// alu_unit_datapath: combinational ADD/SUB/AND/XOR with zero detect
module alu_unit_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             result_zero
);
    always_comb begin
        result = (op == ALU_ADD) ? in1 + in2 :
                 (op == ALU_SUB) ? in1 - in2 :
                 (op == ALU_AND) ? in1 & in2 :
                 (op == ALU_XOR) ? in1 ^ in2 : '0;
        result_zero = (result == '0);
    end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: one-cycle registered ALU with valid pipeline bit
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    alu_unit_if.slave  bus
);
    logic [WIDTH-1:0] result, out_d, out_q;
    logic             result_zero, zero_d, zero_q, valid_q;

    alu_unit_datapath #(.WIDTH(WIDTH)) u_dp (
        .in1        (bus.in1),
        .in2        (bus.in2),
        .op         (bus.op),
        .result     (result),
        .result_zero(result_zero)
    );

    // zero follows the value being written, so it can never be stale
    always_comb begin
        out_d  = bus.in_valid ? result : out_q;
        zero_d = bus.in_valid ? result_zero : zero_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            zero_q  <= zero_d;
            valid_q <= bus.in_valid;
        end
    end

    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and random checks of alu_unit against an arithmetic model
module tb_alu_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int exp_out = 0;
    logic exp_zero = 1'b1;
    logic exp_vld = 1'b0;

    always #5 clk = ~clk;

    alu_unit_if #(.WIDTH(8)) bus ();
    alu_unit #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic int ref_alu(int o, int a, int b);
        case (o)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a ^ b;
            default: return 0;
        endcase
    endfunction

    task automatic check(string tag, int obs, int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(string tag, logic r, logic v, int o, int a, int b);
        @(negedge clk);
        reset        = r;
        bus.in_valid = v;
        bus.op       = 3'(o);
        bus.in1      = 8'(a);
        bus.in2      = 8'(b);
        @(posedge clk);
        #1;
        if (r) begin
            exp_out = 0; exp_zero = 1'b1; exp_vld = 1'b0;
        end else if (v) begin
            exp_out = ref_alu(o, a, b); exp_zero = (exp_out == 0); exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
        check({tag, ".out"}, int'(bus.out), exp_out);
        check({tag, ".zero"}, int'(bus.zero), int'(exp_zero));
        check({tag, ".out_valid"}, int'(bus.out_valid), int'(exp_vld));
        // scramble inputs between edges; only edge-sampled values may matter
        bus.in_valid = 1'($urandom);
        bus.op       = 3'($urandom);
        bus.in1      = 8'($urandom);
        bus.in2      = 8'($urandom);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.op = 3'd0;
        bus.in1 = 8'd0;
        bus.in2 = 8'd0;
        step("reset_with_valid", 1, 1, 0, 8'h05, 8'h03);
        step("add", 0, 1, 0, 8'h05, 8'h03);
        step("add_wrap", 0, 1, 0, 8'hFF, 8'h01);
        step("sub", 0, 1, 1, 8'h05, 8'h03);
        step("sub_borrow", 0, 1, 1, 8'h03, 8'h05);
        step("and", 0, 1, 2, 8'h0F, 8'hF0);
        step("xor", 0, 1, 3, 8'h0F, 8'hF0);
        for (int o = 4; o < 8; o++) step("bad_op", 0, 1, o, 8'hFF, 8'hFF);
        step("b2b_add", 0, 1, 0, 8'h10, 8'h20);
        step("b2b_sub", 0, 1, 1, 8'h10, 8'h20);
        step("b2b_and", 0, 1, 2, 8'h3C, 8'h0F);
        step("b2b_xor", 0, 1, 3, 8'h0F, 8'hF0);
        step("hold1", 0, 0, 0, 8'h01, 8'h01);
        step("hold2", 0, 0, 1, 8'h09, 8'h02);
        step("pre_rst", 0, 1, 0, 8'h40, 8'h02);
        step("mid_reset", 1, 1, 3, 8'h12, 8'h34);
        step("post_reset", 0, 1, 1, 8'h50, 8'h20);
        for (int i = 0; i < 300; i++)
            step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
